// File: rtl/stim_pkg.sv
// ---------------------------------------------------------------------------
// stim_pkg
//   Shared types and constants for the stimulus driver.
//   - state_e       : driver FSM states
//   - DEFAULT_TAPS  : default 8-bit LFSR feedback mask
//   - ERR_EMPTY     : o_err bit set when the DUT produces a word with no
//                     expected value queued
//   - ERR_TIMEOUT   : o_err bit set when DRAIN gives up waiting for the DUT
// ---------------------------------------------------------------------------
package stim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [7:0] DEFAULT_TAPS = 8'hB8;

  localparam int ERR_EMPTY   = 0;
  localparam int ERR_TIMEOUT = 1;

endpackage

// File: rtl/expect_fifo.sv
// ---------------------------------------------------------------------------
// expect_fifo
//   Synchronous FIFO holding the stimulus words already accepted by the DUT,
//   i.e. the expected values still waiting for their DUT output word.
//   The read is registered: o_head shows the popped entry the cycle after
//   i_pop, which lets the storage map onto block RAM.
// Ports
//   i_clk    in   clock, rising edge
//   i_rst_n  in   asynchronous active-low reset
//   i_flush  in   empty the FIFO (pointers and count cleared)
//   i_push   in   write i_data (caller guarantees not full unless popping)
//   i_pop    in   read head (caller guarantees not empty)
//   i_data   in   WIDTH  write data
//   o_head   out  WIDTH  entry read by the previous pop
//   o_count  out  number of stored entries
//   o_full   out  count == DEPTH
//   o_empty  out  count == 0
// ---------------------------------------------------------------------------
module expect_fifo
  import stim_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;

  // Storage has no reset so it can live in RAM.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. A push and a
  // pop on a full FIFO hit the same address; the registered read still
  // returns the old head because the write lands after this edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_head   <= r_mem[r_rd_ptr];
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_count = r_count;
  assign o_full  = (r_count == DEPTH_C);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/stim_driver.sv
// ---------------------------------------------------------------------------
// stim_driver
//   Stimulus and expectation source for a unit-test bench. Generates
//   NUM_TESTS LFSR words, drives them to the DUT over valid/ready, queues
//   every accepted word as an expected value, pairs it with the DUT's next
//   output word and strobes the pair to a scoreboard. o_is_finish is held
//   once the run is complete (or DRAIN timed out).
// Ports
//   i_clk          in   clock, rising edge
//   i_rst_n        in   asynchronous active-low reset
//   i_start        in   start pulse, honoured in IDLE or DONE
//   o_dut_valid    out  stimulus valid
//   i_dut_ready    in   DUT accepts stimulus
//   o_dut_data     out  SIZE_DATA stimulus word (0 while not valid)
//   i_dut_valid    in   DUT output word valid
//   i_dut_data     in   SIZE_DATA DUT output word
//   o_cmp_valid    out  one-cycle compare strobe
//   o_expect_data  out  SIZE_DATA expected value for the compare
//   o_data_out     out  SIZE_DATA captured DUT word for the compare
//   o_is_finish    out  level, high throughout DONE
//   o_busy         out  high in RUN or DRAIN
//   o_err          out  2 sticky: [0] DUT word with empty queue, [1] timeout
// ---------------------------------------------------------------------------
module stim_driver
  import stim_pkg::*;
#(
  parameter int                   SIZE_DATA  = 8,
  parameter int                   NUM_TESTS  = 16,
  parameter int                   FIFO_DEPTH = 4,
  parameter logic [SIZE_DATA-1:0] SEED       = SIZE_DATA'(8'h01),
  parameter logic [SIZE_DATA-1:0] TAPS       = SIZE_DATA'(DEFAULT_TAPS),
  parameter int                   TIMEOUT    = 256
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  output logic                 o_dut_valid,
  input  logic                 i_dut_ready,
  output logic [SIZE_DATA-1:0] o_dut_data,
  input  logic                 i_dut_valid,
  input  logic [SIZE_DATA-1:0] i_dut_data,
  output logic                 o_cmp_valid,
  output logic [SIZE_DATA-1:0] o_expect_data,
  output logic [SIZE_DATA-1:0] o_data_out,
  output logic                 o_is_finish,
  output logic                 o_busy,
  output logic [1:0]           o_err
);

  localparam int CNT_W = $clog2(NUM_TESTS + 1);
  localparam int FCW   = $clog2(FIFO_DEPTH + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]     NUM_C     = CNT_W'(NUM_TESTS);
  localparam logic [FCW-1:0]       DEPTH_C   = FCW'(FIFO_DEPTH);
  localparam logic [TO_W-1:0]      TIMEOUT_C = TO_W'(TIMEOUT);
  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [SIZE_DATA-1:0] SEED_EFF  = (SEED == '0) ? SIZE_DATA'(1) : SEED;

  state_e               r_state;
  state_e               w_state_next;
  logic [SIZE_DATA-1:0] r_lfsr;
  logic                 r_dut_valid;
  logic [CNT_W-1:0]     r_sent_cnt;
  logic [CNT_W-1:0]     r_recv_cnt;
  logic [TO_W-1:0]      r_idle_cnt;
  logic                 r_cmp_valid;
  logic [SIZE_DATA-1:0] r_data_out;
  logic [1:0]           r_err;

  logic                 w_start;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_stall;
  logic                 w_timeout;
  logic                 w_may_send;
  logic                 w_feedback;
  logic [CNT_W-1:0]     w_sent_next;
  logic [FCW-1:0]       w_count_next;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [FCW-1:0]       w_fifo_count;
  logic [SIZE_DATA-1:0] w_fifo_head;

  // ---------------------------------------------------------------- control
  assign w_start   = i_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_stall   = r_dut_valid && !i_dut_ready;
  // Full FIFO can still take a push when a pop frees a slot this cycle.
  assign w_push    = r_dut_valid && i_dut_ready && (!w_fifo_full || w_pop);
  // DUT words outside RUN/DRAIN are not compared.
  assign w_pop     = ((r_state == RUN) || (r_state == DRAIN)) && i_dut_valid && !w_fifo_empty;
  assign w_timeout = (r_state == DRAIN) && (r_idle_cnt == TIMEOUT_C);

  // Valid is decided on the post-transfer counts so it drops right after the
  // transfer that fills the queue or sends the last vector.
  assign w_sent_next  = r_sent_cnt + CNT_W'(w_push);
  assign w_count_next = w_fifo_count + FCW'(w_push) - FCW'(w_pop);
  assign w_may_send   = (r_state == RUN) && (w_count_next < DEPTH_C) && (w_sent_next < NUM_C);

  assign w_feedback = ^(r_lfsr & TAPS);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_next = RUN;
      RUN:     if (r_sent_cnt == NUM_C) w_state_next = DRAIN;
      DRAIN:   if ((r_recv_cnt == NUM_C) || w_timeout) w_state_next = DONE;
      DONE:    if (i_start) w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy      = 1'b0;
    o_is_finish = 1'b0;
    case (r_state)
      RUN, DRAIN: o_busy      = 1'b1;
      DONE:       o_is_finish = 1'b1;
      default:    ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr      <= SEED_EFF;
      r_dut_valid <= 1'b0;
      r_sent_cnt  <= '0;
      r_recv_cnt  <= '0;
      r_cmp_valid <= 1'b0;
      r_data_out  <= '0;
      r_err       <= '0;
    end else begin
      r_cmp_valid <= w_pop;
      if (w_pop) begin
        r_data_out <= i_dut_data;
      end
      if (w_start) begin
        r_lfsr      <= SEED_EFF;
        r_dut_valid <= 1'b0;
        r_sent_cnt  <= '0;
        r_recv_cnt  <= '0;
        r_err       <= '0;
      end else begin
        if (w_push) begin
          r_lfsr     <= {r_lfsr[SIZE_DATA-2:0], w_feedback};
          r_sent_cnt <= w_sent_next;
        end
        if (w_pop) begin
          r_recv_cnt <= r_recv_cnt + CNT_W'(1);
        end
        // A stalled word must stay put until the DUT takes it.
        if (!w_stall) begin
          r_dut_valid <= w_may_send;
        end
        // Checked against the pre-push state: a word pushed this cycle
        // cannot pair with a DUT output arriving in the same cycle.
        if (i_dut_valid && w_fifo_empty) begin
          r_err[ERR_EMPTY] <= 1'b1;
        end
        if (w_timeout) begin
          r_err[ERR_TIMEOUT] <= 1'b1;
        end
      end
    end
  end

  // Idle counter only runs in DRAIN and restarts on every DUT word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idle_cnt <= '0;
    end else if ((r_state != DRAIN) || i_dut_valid) begin
      r_idle_cnt <= '0;
    end else if (!w_timeout) begin
      r_idle_cnt <= r_idle_cnt + TO_W'(1);
    end
  end

  // ---------------------------------------------------------------- queue
  expect_fifo #(
    .WIDTH (SIZE_DATA),
    .DEPTH (FIFO_DEPTH)
  ) u_expect_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (w_start),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (r_lfsr),
    .o_head  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // ---------------------------------------------------------------- outputs
  assign o_dut_valid   = r_dut_valid;
  // Data is gated so every output reads zero out of reset.
  assign o_dut_data    = r_dut_valid ? r_lfsr : '0;
  assign o_cmp_valid   = r_cmp_valid;
  assign o_expect_data = w_fifo_head;
  assign o_data_out    = r_data_out;
  assign o_err         = r_err;

endmodule

// File: tb/tb_stim_driver.sv
// ---------------------------------------------------------------------------
// tb_stim_driver
//   Directed bench for stim_driver (NUM_TESTS=5, FIFO_DEPTH=4, TIMEOUT=256).
//   Expected stimulus 01,02,04,08,11 is the hand-stepped LFSR sequence.
// ---------------------------------------------------------------------------
module tb_stim_driver;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_start;
  logic       o_dut_valid;
  logic       i_dut_ready;
  logic [7:0] o_dut_data;
  logic       i_dut_valid;
  logic [7:0] i_dut_data;
  logic       o_cmp_valid;
  logic [7:0] o_expect_data;
  logic [7:0] o_data_out;
  logic       o_is_finish;
  logic       o_busy;
  logic [1:0] o_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_vec [8];

  always #5 i_clk = ~i_clk;

  stim_driver #(
    .SIZE_DATA  (8),
    .NUM_TESTS  (5),
    .FIFO_DEPTH (4),
    .SEED       (8'h01),
    .TAPS       (8'hB8),
    .TIMEOUT    (256)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .o_dut_valid   (o_dut_valid),
    .i_dut_ready   (i_dut_ready),
    .o_dut_data    (o_dut_data),
    .i_dut_valid   (i_dut_valid),
    .i_dut_data    (i_dut_data),
    .o_cmp_valid   (o_cmp_valid),
    .o_expect_data (o_expect_data),
    .o_data_out    (o_data_out),
    .o_is_finish   (o_is_finish),
    .o_busy        (o_busy),
    .o_err         (o_err)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Full run against a 1-cycle passthrough DUT; toggle=1 stalls ready on
  // alternate cycles.
  task automatic run_pass(input bit toggle);
    int         nsent;
    int         ncmp;
    logic       xfer;
    logic       stall;
    logic [7:0] sd;
    nsent = 0;
    ncmp  = 0;
    pulse_start();
    check("start_busy", o_busy, 1);
    for (int cyc = 0; cyc < 200 && !o_is_finish; cyc++) begin
      i_dut_ready = toggle ? cyc[0] : 1'b1;
      xfer  = o_dut_valid && i_dut_ready;
      stall = o_dut_valid && !i_dut_ready;
      sd    = o_dut_data;
      if (xfer) begin
        $display("xfer  data=%02h", sd);
        if (nsent < 8) check("xfer_data", sd, exp_vec[nsent]);
        nsent++;
      end
      tick();
      i_dut_valid = xfer;
      i_dut_data  = sd;
      if (stall) begin
        check("stall_valid", o_dut_valid, 1);
        check("stall_data", o_dut_data, sd);
      end
      if (o_cmp_valid) begin
        $display("cmp   expect=%02h got=%02h", o_expect_data, o_data_out);
        check("cmp_pair", o_data_out, o_expect_data);
        if (ncmp < 8) check("cmp_expect", o_expect_data, exp_vec[ncmp]);
        ncmp++;
      end
    end
    i_dut_valid = 1'b0;
    i_dut_ready = 1'b0;
    check("run_finish", o_is_finish, 1);
    check("run_sent", nsent, 5);
    check("run_cmps", ncmp, 5);
    check("run_err", o_err, 0);
    check("run_busy", o_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_vec = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
    i_rst_n     = 1'b0;
    i_start     = 1'b0;
    i_dut_ready = 1'b0;
    i_dut_valid = 1'b0;
    i_dut_data  = 8'h00;

    // ---- reset state
    tick();
    check("rst_outputs", {o_dut_valid, o_dut_data, o_cmp_valid, o_expect_data,
                          o_data_out, o_is_finish, o_busy, o_err}, 0);
    i_rst_n = 1'b1;
    tick();
    check("idle_busy", o_busy, 0);

    // ---- 1: ready=1 passthrough
    run_pass(1'b0);

    // ---- 2: ready toggling, restart from DONE
    run_pass(1'b1);

    // ---- 3: DUT output withheld -> exactly FIFO_DEPTH transfers
    pulse_start();
    i_dut_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (o_dut_valid) begin
        $display("xfer  data=%02h", o_dut_data);
        if (n < 8) check("t3_data", o_dut_data, exp_vec[n]);
        n++;
      end
      tick();
    end
    check("t3_xfers", n, 4);
    check("t3_valid_low", o_dut_valid, 0);
    i_dut_valid = 1'b1;
    i_dut_data  = 8'h01;
    tick();
    i_dut_valid = 1'b0;
    check("t3_cmp_valid", o_cmp_valid, 1);
    check("t3_cmp_expect", o_expect_data, 8'h01);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (o_dut_valid) begin
        $display("xfer  data=%02h", o_dut_data);
        check("t3_resume_data", o_dut_data, 8'h11);
        n++;
      end
      tick();
    end
    check("t3_resume_xfers", n, 1);
    for (int k = 1; k < 5; k++) begin
      i_dut_valid = 1'b1;
      i_dut_data  = exp_vec[k];
      tick();
      $display("cmp   expect=%02h got=%02h", o_expect_data, o_data_out);
      check("t3_drain_strobe", o_cmp_valid, 1);
      check("t3_drain_expect", o_expect_data, exp_vec[k]);
      check("t3_drain_data", o_data_out, exp_vec[k]);
    end
    i_dut_valid = 1'b0;
    tick();
    check("t3_finish", o_is_finish, 1);
    check("t3_err", o_err, 0);

    // ---- 4: DUT word with empty queue
    i_dut_ready = 1'b0;
    pulse_start();
    check("t4_err_cleared", o_err, 0);
    check("t4_finish_drop", o_is_finish, 0);
    i_dut_valid = 1'b1;
    i_dut_data  = 8'h5A;
    tick();
    i_dut_valid = 1'b0;
    check("t4_err_empty", o_err, 2'b01);
    check("t4_no_cmp", o_cmp_valid, 0);

    // ---- 5: timeout in DRAIN
    i_dut_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (o_dut_valid) n++;
      tick();
    end
    check("t5_xfers", n, 4);
    i_dut_valid = 1'b1;
    i_dut_data  = 8'h01;
    tick();
    i_dut_valid = 1'b0;
    check("t5_cmp_expect", o_expect_data, 8'h01);
    for (int k = 0; k < 10 && !o_dut_valid; k++) tick();
    check("t5_last_data", o_dut_data, 8'h11);
    tick();
    n = 0;
    for (int k = 0; k < 400 && !o_is_finish; k++) begin
      tick();
      n++;
    end
    check("t5_timeout_cycles", n, 258);
    check("t5_err", o_err, 2'b11);
    check("t5_busy", o_busy, 0);

    // ---- 6: async reset mid-RUN, then fresh run from 01
    pulse_start();
    i_dut_ready = 1'b1;
    tick();
    tick();
    tick();
    check("t6_busy_before", o_busy, 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("t6_rst_outputs", {o_dut_valid, o_dut_data, o_cmp_valid, o_expect_data,
                             o_data_out, o_is_finish, o_busy, o_err}, 0);
    @(posedge i_clk);
    #1;
    i_rst_n     = 1'b1;
    i_dut_ready = 1'b0;
    tick();
    run_pass(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
